// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_D_HI   = 3'd3,
    ST_D_LO   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  // One instruction word as it is written to memory, big-endian byte order.
  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } word_t;

endpackage

// File: rtl/byte_pair_packer.sv
// Packs hi/lo byte pairs into words, keeps the running XOR and issues the
// one-cycle registered memory write.
module byte_pair_packer
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [7:0]        byte_in,
  input  logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output word_t             wr_data,
  output logic [7:0]        xor_acc
);

  logic [7:0] hi_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q    <= '0;
      xor_acc <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= lo_en;
      if (clr) begin
        xor_acc <= '0;
      end else if (hi_en || lo_en) begin
        xor_acc <= xor_acc ^ byte_in;
      end
      if (hi_en) begin
        hi_q <= byte_in;
      end
      // Address and data only move with the strobe, so they hold between writes.
      if (lo_en) begin
        wr_addr    <= addr;
        wr_data.hi <= hi_q;
        wr_data.lo <= byte_in;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: parses SYNC/count/words/checksum, writes
// instruction memory and releases the core only after a good checksum.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       MAX_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]        SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_wr_addr,
  output logic [15:0]       im_wr_data,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wl_d;
  logic             accept;
  logic             clr, hi_en, lo_en;
  logic             rx_ready_d, done_d, error_d;
  logic [7:0]       xor_acc;
  word_t            wr_word;
  logic [ADDR_W-1:0] wr_addr_next;

  assign accept       = rx_valid && rx_ready;
  assign wr_addr_next = BASE_ADDR + ADDR_W'(words_loaded);
  assign im_wr_data   = wr_word;

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_SYNC;
      cnt_q        <= '0;
      words_loaded <= '0;
      rx_ready     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      core_rst     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_loaded <= wl_d;
      rx_ready     <= rx_ready_d;
      done         <= done_d;
      error        <= error_d;
      core_rst     <= done_d;
    end
  end

  // Next-state and control decode; nothing moves unless a byte is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wl_d    = words_loaded;
    clr     = 1'b0;
    hi_en   = 1'b0;
    lo_en   = 1'b0;
    if (accept) begin
      case (state_q)
        ST_SYNC: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_CNT_HI;
            clr     = 1'b1;
            wl_d    = '0;
          end
        end
        ST_CNT_HI: begin
          cnt_d   = {rx_data, cnt_q[7:0]};
          state_d = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          cnt_d = {cnt_q[CNT_W-1:8], rx_data};
          if ((cnt_d == '0) || ({1'b0, cnt_d} > (CNT_W+1)'(MAX_WORDS))) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_D_HI;
          end
        end
        ST_D_HI: begin
          hi_en   = 1'b1;
          state_d = ST_D_LO;
        end
        ST_D_LO: begin
          lo_en   = 1'b1;
          wl_d    = words_loaded + CNT_W'(1);
          state_d = (wl_d == cnt_q) ? ST_CSUM : ST_D_HI;
        end
        ST_CSUM: begin
          state_d = (rx_data == xor_acc) ? ST_DONE : ST_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    rx_ready_d = !(state_d inside {ST_DONE, ST_ERR});
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  byte_pair_packer #(
    .ADDR_W(ADDR_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .hi_en   (hi_en),
    .lo_en   (lo_en),
    .byte_in (rx_data),
    .addr    (wr_addr_next),
    .wr_en   (im_wr_en),
    .wr_addr (im_wr_addr),
    .wr_data (wr_word),
    .xor_acc (xor_acc)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_wr_en;
  logic [15:0] im_wr_addr;
  logic [15:0] im_wr_data;
  logic        core_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];
  logic        prev_we = 1'b0;
  int          dbl_strobe = 0;

  imem_boot_loader #(
    .ADDR_W(16), .MAX_WORDS(256), .BASE_ADDR(16'h0), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
    .core_rst(core_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Capture memory writes away from the active edge.
  always @(negedge clk) begin
    if (im_wr_en) begin
      wq_addr.push_back(im_wr_addr);
      wq_data.push_back(im_wr_data);
    end
    if (prev_we && im_wr_en) dbl_strobe++;
    prev_we <= im_wr_en;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wq_addr.delete();
    wq_data.delete();
  endtask

  // Present one byte and return just after the edge that accepts it.
  task automatic send(input logic [7:0] b, input bit gap = 1'b0);
    bit ok = 1'b0;
    if (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout byte=%h not accepted within 50 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                              input logic exp_core, input logic exp_ready, input int exp_writes);
    checks++;
    if (done !== exp_done || error !== exp_err || core_rst !== exp_core ||
        rx_ready !== exp_ready || wq_addr.size() != exp_writes) begin
      errors++;
      $display("FAIL %s status: done=%b error=%b core_rst=%b rx_ready=%b writes=%0d, required %b %b %b %b %0d",
               name, done, error, core_rst, rx_ready, wq_addr.size(),
               exp_done, exp_err, exp_core, exp_ready, exp_writes);
    end
  endtask

  task automatic check_write(input string name, input int idx, input logic [15:0] a,
                             input logic [15:0] d);
    checks++;
    if (idx >= wq_addr.size()) begin
      errors++;
      $display("FAIL %s write%0d missing, required (%h,%h)", name, idx, a, d);
    end else if (wq_addr[idx] !== a || wq_data[idx] !== d) begin
      errors++;
      $display("FAIL %s write%0d got (%h,%h) required (%h,%h)", name, idx,
               wq_addr[idx], wq_data[idx], a, d);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (rx_ready !== 1'b1 || im_wr_en !== 1'b0 || core_rst !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || words_loaded !== 16'd0 || im_wr_addr !== 16'd0 || im_wr_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_values got ready=%b we=%b core=%b done=%b err=%b wl=%0d addr=%h data=%h, required 1 0 0 0 0 0 0 0",
               rx_ready, im_wr_en, core_rst, done, error, words_loaded, im_wr_addr, im_wr_data);
    end
  endtask

  task automatic test_basic_frame();
    apply_reset();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12);
    #1;
    checks++;
    if (im_wr_en !== 1'b0) begin
      errors++; $display("FAIL basic_no_strobe_after_hi got %b required 0", im_wr_en);
    end
    send(8'h34);
    #1;
    checks++;
    if (im_wr_en !== 1'b1 || im_wr_addr !== 16'h0000 || im_wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL basic_strobe_latency got we=%b (%h,%h) required 1 (0000,1234)",
               im_wr_en, im_wr_addr, im_wr_data);
    end
    send(8'hAB);
    #1;
    checks++;
    if (im_wr_en !== 1'b0 || im_wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL basic_hold got we=%b data=%h required 0 1234", im_wr_en, im_wr_data);
    end
    send(8'hCD);
    #1;
    checks++;
    if (core_rst !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_pre_csum got core_rst=%b done=%b required 0 0", core_rst, done);
    end
    send(8'h40);
    idle(2);
    check_status("basic", 1'b1, 1'b0, 1'b1, 1'b0, 2);
    check_write("basic", 0, 16'h0000, 16'h1234);
    check_write("basic", 1, 16'h0001, 16'hABCD);
    checks++;
    if (words_loaded !== 16'd2) begin
      errors++; $display("FAIL basic_words_loaded got %0d required 2", words_loaded);
    end
  endtask

  task automatic test_garbage();
    apply_reset();
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h00); send(8'h01);
    send(8'hBE); send(8'hEF); send(8'h51);
    idle(2);
    check_status("garbage", 1'b1, 1'b0, 1'b1, 1'b0, 1);
    check_write("garbage", 0, 16'h0000, 16'hBEEF);
  endtask

  task automatic test_bad_count();
    apply_reset();
    send(8'hA5); send(8'h00); send(8'h00);
    idle(2);
    check_status("count_zero", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    apply_reset();
    send(8'hA5); send(8'h01); send(8'h01);
    idle(2);
    check_status("count_257", 1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_bad_csum();
    apply_reset();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h45);
    idle(2);
    check_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    check_write("bad_csum", 0, 16'h0000, 16'h1122);
    check_write("bad_csum", 1, 16'h0001, 16'h3344);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    send(8'hA5); send(8'h00); send(8'h04);
    for (int k = 0; k < 3; k++) begin
      send(8'h00); send(8'(k + 1));
    end
    send(8'h77);
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (wq_addr.size() != 3) begin
      errors++; $display("FAIL mid_reset_writes got %0d required 3", wq_addr.size());
    end
    check_write("mid_reset", 2, 16'h0002, 16'h0003);
    checks++;
    if (rx_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || core_rst !== 1'b0 ||
        words_loaded !== 16'd0 || im_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_values got ready=%b done=%b err=%b core=%b wl=%0d we=%b required 1 0 0 0 0 0",
               rx_ready, done, error, core_rst, words_loaded, im_wr_en);
    end
    wq_addr.delete();
    wq_data.delete();
    send(8'hA5); send(8'h00); send(8'h01); send(8'hCA); send(8'hFE); send(8'h34);
    idle(2);
    check_status("after_reset", 1'b1, 1'b0, 1'b1, 1'b0, 1);
    check_write("after_reset", 0, 16'h0000, 16'hCAFE);
  endtask

  task automatic test_random_gaps();
    logic [7:0] cs = 8'h00;
    logic [7:0] hi, lo;
    apply_reset();
    send(8'hA5, 1'($urandom_range(0, 1)));
    send(8'h01, 1'($urandom_range(0, 1)));
    send(8'h00, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 256; k++) begin
      hi = 8'(k) ^ 8'h5A;
      lo = 8'(k);
      cs = cs ^ hi ^ lo;
      send(hi, 1'($urandom_range(0, 1)));
      send(lo, 1'($urandom_range(0, 1)));
    end
    send(cs, 1'($urandom_range(0, 1)));
    idle(2);
    check_status("gaps", 1'b1, 1'b0, 1'b1, 1'b0, 256);
    for (int k = 0; k < 256; k++) begin
      check_write("gaps", k, 16'(k), {8'(k) ^ 8'h5A, 8'(k)});
    end
    checks++;
    if (words_loaded !== 16'd256) begin
      errors++; $display("FAIL gaps_words_loaded got %0d required 256", words_loaded);
    end
  endtask

  task automatic test_single_strobe();
    checks++;
    if (dbl_strobe != 0) begin
      errors++; $display("FAIL strobe_width got %0d adjacent strobes required 0", dbl_strobe);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    test_reset();
    test_basic_frame();
    test_garbage();
    test_bad_count();
    test_bad_csum();
    test_mid_reset();
    test_random_gaps();
    test_single_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
